// File: rtl/mismatch_monitor.sv
// mismatch_monitor: synchronizes and debounces the dual2 comparator's
// inequality flag, counts debounced rising mismatch events, and shows the
// count, a sticky mismatch-seen flag and the debounced level on LEDR.
// Compile-time option: define MISMATCH_MONITOR_SAT_EN to make the event
// counter saturate at its maximum instead of wrapping to zero.
module mismatch_monitor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic       neq,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [15:0]      TIMER_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             rst_n;
  logic             clr_n;
  logic             unused_keys;

  logic             s1_reg;
  logic             s2_reg;
  state_t           state_reg;
  state_t           state_next;
  logic [15:0]      timer_reg;
  logic [15:0]      timer_next;
  logic             mismatch_event;
  logic [CNT_W-1:0] count_reg;
  logic             seen_reg;

  assign rst_n       = KEY[0];
  assign clr_n       = KEY[1];
  assign unused_keys = ^KEY[3:2];

  // Two-flop synchronizer for the asynchronous comparator flag.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= neq;
      s2_reg <= s1_reg;
    end
  end

  // Debounce FSM state and timer registers; clear does not touch them.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_reg <= LOW;
      timer_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Next-state logic: a level change is accepted after DEBOUNCE_CYCLES
  // consecutive opposite samples; the rising acceptance is the event.
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    mismatch_event = 1'b0;
    case (state_reg)
      LOW: begin
        if (s2_reg) begin
          state_next = WAIT_HIGH;
          timer_next = 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (!s2_reg) begin
          state_next = LOW;
          timer_next = 16'd0;
        end else if (timer_reg == TIMER_LAST) begin
          state_next     = HIGH;
          timer_next     = 16'd0;
          mismatch_event = 1'b1;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      HIGH: begin
        if (!s2_reg) begin
          state_next = WAIT_LOW;
          timer_next = 16'd1;
        end
      end
      WAIT_LOW: begin
        if (s2_reg) begin
          state_next = HIGH;
          timer_next = 16'd0;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = LOW;
          timer_next = 16'd0;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      default: begin
        state_next = LOW;
        timer_next = 16'd0;
      end
    endcase
  end

  // Event counter and sticky flag; reset beats clear, clear beats an event.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      count_reg <= '0;
      seen_reg  <= 1'b0;
    end else if (!clr_n) begin
      count_reg <= '0;
      seen_reg  <= 1'b0;
    end else if (mismatch_event) begin
      seen_reg <= 1'b1;
`ifdef MISMATCH_MONITOR_SAT_EN
      if (count_reg != CNT_MAX) begin
        count_reg <= count_reg + CNT_ONE;
      end
`else
      count_reg <= count_reg + CNT_ONE;
`endif
    end
  end

  // Count field of LEDR; bits beyond CNT_W read as zero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_count_led
      if (gi < CNT_W) begin : g_bit
        assign LEDR[gi] = count_reg[gi];
      end else begin : g_zero
        assign LEDR[gi] = 1'b0;
      end
    end
  endgenerate

  assign LEDR[8] = seen_reg;
  assign LEDR[9] = (state_reg == HIGH) || (state_reg == WAIT_LOW);

endmodule

// File: tb/tb_mismatch_monitor.sv
// Testbench for mismatch_monitor (DEBOUNCE_CYCLES=4, CNT_W=8). A run-length
// reference model predicts LEDR every clock; directed steps cover reset,
// latency, glitch rejection, clear priority, counter overflow and reset
// during a pending event, plus a randomized section.
module tb_mismatch_monitor;

  localparam int DEB   = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic [3:0] key = 4'b1111;
  logic       neq = 1'b0;
  logic [9:0] ledr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: two-sample delay line, debounced level, run of
  // samples disagreeing with the level, event count and sticky flag.
  logic m_d1, m_d2;
  logic m_level;
  int   m_run;
  int   m_count;
  logic m_seen;

  mismatch_monitor #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .neq     (neq),
    .LEDR    (ledr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model from the inputs seen at that edge,
  // then compare the whole LEDR bus just after the edge.
  task automatic tick();
    logic x;
    logic ev;
    logic [7:0] cnt8;
    @(posedge clk);
    if (!key[0]) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0;
      m_count = 0; m_seen = 1'b0;
    end else begin
      ev   = 1'b0;
      x    = m_d2;
      m_d2 = m_d1;
      m_d1 = neq;
      if (x != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = x;
          m_run   = 0;
          ev      = x;
        end
      end else begin
        m_run = 0;
      end
      if (!key[1]) begin
        m_count = 0;
        m_seen  = 1'b0;
      end else if (ev) begin
        m_seen = 1'b1;
`ifdef MISMATCH_MONITOR_SAT_EN
        if (m_count < (1 << CNT_W) - 1) m_count++;
`else
        m_count = (m_count + 1) % (1 << CNT_W);
`endif
      end
    end
    #1;
    cnt8 = 8'(m_count);
    check("ledr", {22'd0, ledr}, {22'd0, m_level, m_seen, cnt8});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int   first_edge;
    logic high_seen;
    int   run_len;

    m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0;
    m_count = 0; m_seen = 1'b0;

    // Reset for two edges, then release.
    key = 4'b1110;
    neq = 1'b0;
    ticks(2);
    check("reset_ledr", {22'd0, ledr}, 32'd0);
    key = 4'b1111;
    ticks(2);

    // Held mismatch: count goes 0->1 exactly DEB+2 edges after first sample.
    neq = 1'b1;
    first_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first_edge == 0 && ledr[7:0] == 8'd1) first_edge = i;
    end
    check("latency_edges", first_edge, DEB + 2);
    check("held_count", {24'd0, ledr[7:0]}, 32'd1);
    check("held_seen", {31'd0, ledr[8]}, 32'd1);
    check("held_level", {31'd0, ledr[9]}, 32'd1);
    neq = 1'b0;
    ticks(10);
    check("released_level", {31'd0, ledr[9]}, 32'd0);

    // Clear the count before the glitch test.
    key = 4'b1101;
    tick();
    check("clear_count", {24'd0, ledr[7:0]}, 32'd0);
    check("clear_seen", {31'd0, ledr[8]}, 32'd0);
    key = 4'b1111;

    // Short glitches: 3 high / 3 low, 10 repeats, must never be accepted.
    high_seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      neq = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); high_seen |= ledr[9]; end
      neq = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); high_seen |= ledr[9]; end
    end
    ticks(4);
    check("glitch_level", {31'd0, high_seen}, 32'd0);
    check("glitch_count", {24'd0, ledr[7:0]}, 32'd0);

    // Four clean events, then a clear on the edge of the fifth.
    for (int e = 0; e < 4; e++) begin
      neq = 1'b1; ticks(8);
      neq = 1'b0; ticks(8);
    end
    check("four_events", {24'd0, ledr[7:0]}, 32'd4);
    neq = 1'b1;
    ticks(DEB + 1);
    check("pre_clear_count", {24'd0, ledr[7:0]}, 32'd4);
    key = 4'b1101;
    tick();
    check("clear_wins_count", {24'd0, ledr[7:0]}, 32'd0);
    check("clear_wins_seen", {31'd0, ledr[8]}, 32'd0);
    key = 4'b1111;
    ticks(10);
    check("no_late_event", {24'd0, ledr[7:0]}, 32'd0);
    neq = 1'b0;
    ticks(10);

    // Reset while WAIT_HIGH timer is 2: the pending event is discarded.
    neq = 1'b1;
    ticks(4);
    key = 4'b1110;
    neq = 1'b0;
    tick();
    check("midwait_reset", {22'd0, ledr}, 32'd0);
    key = 4'b1111;
    ticks(20);
    check("after_midwait", {22'd0, ledr}, 32'd0);

    // Randomized runs with occasional clear and reset.
    for (int r = 0; r < 80; r++) begin
      neq = 1'($urandom_range(0, 1));
      run_len = $urandom_range(1, 8);
      for (int i = 0; i < run_len; i++) begin
        key[3:2] = 2'($urandom_range(0, 3));
        key[1]   = ($urandom_range(0, 39) != 0);
        key[0]   = ($urandom_range(0, 149) != 0);
        tick();
      end
    end
    key = 4'b1111;
    neq = 1'b0;
    ticks(10);

    // 256 clean events from zero: wrap or saturate at the top.
    key = 4'b1110;
    ticks(2);
    key = 4'b1111;
    for (int e = 0; e < 256; e++) begin
      neq = 1'b1; ticks(8);
      neq = 1'b0; ticks(8);
      if (e == 254) check("count_at_max", {24'd0, ledr[7:0]}, 32'd255);
    end
`ifdef MISMATCH_MONITOR_SAT_EN
    check("overflow_count", {24'd0, ledr[7:0]}, 32'd255);
`else
    check("overflow_count", {24'd0, ledr[7:0]}, 32'd0);
`endif
    check("overflow_seen", {31'd0, ledr[8]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mismatch_monitor.md
MISMATCH_MONITOR -- requirements
Module: mismatch_monitor

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 16 and set the number of consecutive equal synchronized samples needed to accept a level change (legal range 2..65535).
REQ-002 The parameter CNT_W SHALL default to 8 and set the event counter width.
REQ-003 CLOCK_50  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 KEY  input  4  SHALL carry the pushbuttons: KEY[0] is reset (synchronous, active-low), KEY[1] is counter clear (synchronous, active-low), and KEY[3:2] are unused.
REQ-005 neq  input  1  SHALL be the asynchronous inequality flag from the dual2 comparator (1 = operands differ).
REQ-006 LEDR  output  10  SHALL present: LEDR[CNT_W-1:0] = event count, LEDR[8] = sticky mismatch-seen, LEDR[9] = debounced mismatch level.

Function
REQ-007 neq SHALL pass through a two-flop synchronizer (s1, s2), and only s2 SHALL be used by the FSM.
REQ-008 The debounce FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW, with a 16-bit timer.
REQ-009 LOW: s2=1 -> WAIT_HIGH with timer=1; else stay in LOW.
REQ-010 WAIT_HIGH: s2=0 -> LOW with timer=0; else if timer==DEBOUNCE_CYCLES-1 -> HIGH; else timer+1.
REQ-011 HIGH: s2=0 -> WAIT_LOW with timer=1; else stay in HIGH.
REQ-012 WAIT_LOW: s2=1 -> HIGH with timer=0; else if timer==DEBOUNCE_CYCLES-1 -> LOW; else timer+1.
REQ-013 LEDR[9] SHALL be 1 exactly when the state is HIGH or WAIT_LOW.
REQ-014 A mismatch event SHALL occur only on the WAIT_HIGH->HIGH transition.
REQ-015 On that same clock edge, the count SHALL increment and LEDR[8] SHALL set.
REQ-016 Total latency SHALL be DEBOUNCE_CYCLES+2 rising edges from the first edge sampling neq=1 to the edge updating the count, provided neq stays high.
REQ-017 Glitches on neq shorter than DEBOUNCE_CYCLES sampled cycles SHALL produce no event and no LEDR[9] change.
REQ-018 While KEY[1]=0, the count and LEDR[8] SHALL be 0 on the next edge, and the FSM and synchronizer SHALL be unaffected.
REQ-019 If a clear and an event coincide on the same edge, the clear SHALL win: count=0, LEDR[8]=0, and the event is lost.
REQ-020 At the count maximum 2^CNT_W-1, a further event SHALL follow REQ-025.

Reset
REQ-021 With KEY[0]=0 at a rising edge, the block SHALL load: s1=s2=0, state=LOW, timer=0, count=0, LEDR=10'b0.
REQ-022 Reset SHALL take priority over clear and events, including mid-WAIT_HIGH, where the pending event is discarded.
REQ-023 Reset SHALL have no asynchronous path; outputs SHALL hold their values until the reset edge.

Configuration
REQ-024 The macro MISMATCH_MONITOR_SAT_EN SHALL select the counter overflow behaviour at compile time.
REQ-025 With MISMATCH_MONITOR_SAT_EN defined, the count SHALL saturate at 2^CNT_W-1 while LEDR[8] still sets; without it, the count SHALL wrap from 2^CNT_W-1 to 0.

Verification (bench uses DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-026 The bench SHALL drive KEY[0]=0 for 2 edges, then 1 -> LEDR=0 and state LOW.
REQ-027 The bench SHALL drive neq=1 held 20 cycles -> count 0->1 exactly 6 edges after the first sampling edge, LEDR[8]=1, LEDR[9]=1.
REQ-028 The bench SHALL drive neq pulses of 3 cycles high / 3 low, 10 repeats -> count stays 0 and LEDR[9] stays 0.
REQ-029 The bench SHALL drive KEY[1]=0 on the same edge the count would go 4->5 -> count=0 and LEDR[8]=0 next edge, with no increment after.
REQ-030 The bench SHALL produce 256 clean events from count 0 -> count=255 with MISMATCH_MONITOR_SAT_EN defined, and count=0 (LEDR[8]=1) without it.
REQ-031 The bench SHALL assert KEY[0]=0 during WAIT_HIGH (timer=2) -> next edge state LOW, count unchanged at 0, and no event after release while neq stays 0.
